// File: rtl/kws_pkg.sv
// Shared constants and FSM state type for the keyword-spotting decision filter.
package kws_pkg;
    localparam int KWS_NUM_KEYWORDS = 10;
    localparam int KWS_WINDOW       = 8;
    localparam int KWS_HOLDOFF      = 16;
    localparam int KWS_IDX_W        = $clog2(KWS_NUM_KEYWORDS);
    localparam int KWS_CNT_W        = $clog2(KWS_WINDOW + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REPORT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } kws_state_t;
endpackage

// File: rtl/kws_hist_ring.sv
// Sliding window of keyword vectors with per-keyword running hit counters.
module kws_hist_ring #(
    parameter int NUM_KEYWORDS = 10,
    parameter int WINDOW       = 8,
    parameter int CNT_W        = $clog2(WINDOW + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr,
    input  logic                                 push,
    input  logic [NUM_KEYWORDS-1:0]              din,
    output logic [NUM_KEYWORDS-1:0][CNT_W-1:0]   cnt
);
    localparam int PTR_W = $clog2(WINDOW);

    logic [WINDOW-1:0][NUM_KEYWORDS-1:0] hist;
    logic [PTR_W-1:0]                    wptr;
    logic [CNT_W-1:0]                    fill;
    logic                                full;
    logic [NUM_KEYWORDS-1:0]             oldest;

    // Once full, the write pointer sits on the oldest entry, which leaves as the new one enters.
    assign full   = (fill == CNT_W'(WINDOW));
    assign oldest = full ? hist[wptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            wptr <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            wptr <= '0;
            fill <= '0;
        end else if (push) begin
            hist[wptr] <= din;
            wptr       <= (wptr == PTR_W'(WINDOW - 1)) ? '0 : wptr + 1'b1;
            if (!full)
                fill <= fill + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_KEYWORDS; k++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt_q <= '0;
            else if (clr)
                cnt_q <= '0;
            else if (push)
                cnt_q <= cnt_q + CNT_W'(din[k]) - CNT_W'(oldest[k]);
        end
        assign cnt[k] = cnt_q;
    end
endmodule

// File: rtl/kws_decision_filter.sv
// Picks the dominant keyword over a sliding frame window, reports it over valid/ready, then holds off.
module kws_decision_filter
    import kws_pkg::*;
#(
    parameter int NUM_KEYWORDS = KWS_NUM_KEYWORDS,
    parameter int WINDOW       = KWS_WINDOW,
    parameter int HOLDOFF      = KWS_HOLDOFF,
    parameter int IDX_W        = $clog2(NUM_KEYWORDS),
    parameter int CNT_W        = $clog2(WINDOW + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_KEYWORDS-1:0] kws_result,
    input  logic                    kws_valid,
    input  logic [CNT_W-1:0]        cfg_thresh,
    output logic                    det_valid,
    output logic [IDX_W-1:0]        det_keyword,
    output logic [CNT_W-1:0]        det_count,
    input  logic                    det_ready,
    output logic                    frame_drop
);
    localparam int HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int HOLD_LAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

    kws_state_t                            state;
    logic                                  eval;
    logic [HOLD_W-1:0]                     hold_cnt;
    logic [NUM_KEYWORDS-1:0][CNT_W-1:0]    cnt;
    logic                                  accept;
    logic                                  detect;
    logic                                  found;
    logic [IDX_W-1:0]                      best_idx;
    logic [CNT_W-1:0]                      best_cnt;

    assign accept     = kws_valid && (state == ST_IDLE);
    assign detect     = eval && (state == ST_IDLE) && found;
    assign frame_drop = kws_valid && (state != ST_IDLE);

    kws_hist_ring #(
        .NUM_KEYWORDS (NUM_KEYWORDS),
        .WINDOW       (WINDOW),
        .CNT_W        (CNT_W)
    ) u_ring (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (detect),
        .push  (accept),
        .din   (kws_result),
        .cnt   (cnt)
    );

    // Strict '>' keeps the lowest index on equal counts.
    always_comb begin
        found    = 1'b0;
        best_idx = '0;
        best_cnt = '0;
        for (int k = 0; k < NUM_KEYWORDS; k++) begin
            if ((cfg_thresh != '0) && (cnt[k] >= cfg_thresh) && (!found || (cnt[k] > best_cnt))) begin
                found    = 1'b1;
                best_idx = IDX_W'(k);
                best_cnt = cnt[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            eval        <= 1'b0;
            hold_cnt    <= '0;
            det_valid   <= 1'b0;
            det_keyword <= '0;
            det_count   <= '0;
        end else begin
            eval <= accept;
            case (state)
                ST_IDLE: begin
                    if (detect) begin
                        state       <= ST_REPORT;
                        det_valid   <= 1'b1;
                        det_keyword <= best_idx;
                        det_count   <= best_cnt;
                    end
                end
                ST_REPORT: begin
                    // A frame arriving with the accept is dropped and not charged to holdoff.
                    if (det_ready) begin
                        det_valid <= 1'b0;
                        hold_cnt  <= '0;
                        state     <= (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (kws_valid) begin
                        if (hold_cnt == HOLD_W'(HOLD_LAST)) begin
                            state    <= ST_IDLE;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kws_decision_filter.sv
// Randomized and directed bench for kws_decision_filter against a queue-based window model.
module tb_kws_decision_filter;
    localparam int NK    = 10;
    localparam int WIN   = 8;
    localparam int HOLD  = 4;
    localparam int IDX_W = $clog2(NK);
    localparam int CNT_W = $clog2(WIN + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NK-1:0]    kws_result = '0;
    logic             kws_valid = 1'b0;
    logic [CNT_W-1:0] cfg_thresh = '0;
    logic             det_valid;
    logic [IDX_W-1:0] det_keyword;
    logic [CNT_W-1:0] det_count;
    logic             det_ready = 1'b0;
    logic             frame_drop;

    kws_decision_filter #(
        .NUM_KEYWORDS (NK),
        .WINDOW       (WIN),
        .HOLDOFF      (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .kws_result  (kws_result),
        .kws_valid   (kws_valid),
        .cfg_thresh  (cfg_thresh),
        .det_valid   (det_valid),
        .det_keyword (det_keyword),
        .det_count   (det_count),
        .det_ready   (det_ready),
        .frame_drop  (frame_drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int drops    = 0;

    // Behavioural model: the window is simply the last WIN accepted frames.
    logic [NK-1:0] m_q[$];
    bit            m_pending;
    int            m_hold_left;
    bit            m_eval;
    int            m_kw, m_cnt;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int hits(input int k);
        int c = 0;
        foreach (m_q[i]) c += int'(m_q[i][k]);
        return c;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pending   = 0;
        m_hold_left = 0;
        m_eval      = 0;
        m_kw        = 0;
        m_cnt       = 0;
    endtask

    task automatic model_step(input bit kv, input logic [NK-1:0] res, input bit rdy);
        bit idle;
        bit det;
        int best, bc, c;
        idle = !m_pending && (m_hold_left == 0);
        det  = 0;
        if (m_pending) begin
            if (rdy) begin
                m_pending   = 0;
                m_hold_left = HOLD;
            end
        end else if (m_hold_left > 0) begin
            if (kv) m_hold_left--;
        end else begin
            if (m_eval && cfg_thresh != 0) begin
                best = -1;
                bc   = 0;
                for (int k = 0; k < NK; k++) begin
                    c = hits(k);
                    if (c >= int'(cfg_thresh) && c > bc) begin
                        best = k;
                        bc   = c;
                    end
                end
                if (best >= 0) begin
                    det       = 1;
                    m_pending = 1;
                    m_kw      = best;
                    m_cnt     = bc;
                    m_q.delete();
                end
            end
            if (kv && !det) begin
                m_q.push_back(res);
                if (m_q.size() > WIN) void'(m_q.pop_front());
            end
        end
        m_eval = idle && kv;
    endtask

    // One clock: drive at negedge, check combinational drop, step model at posedge, check regs at negedge.
    task automatic cycle(input bit kv, input logic [NK-1:0] res, input bit rdy);
        bit exp_drop;
        kws_valid  = kv;
        kws_result = res;
        det_ready  = rdy;
        exp_drop   = kv && (m_pending || m_hold_left > 0);
        #1;
        check("frame_drop", int'(frame_drop), int'(exp_drop));
        if (frame_drop) drops++;
        @(posedge clk);
        model_step(kv, res, rdy);
        @(negedge clk);
        check("det_valid", int'(det_valid), int'(m_pending));
        if (m_pending) begin
            check("det_keyword", int'(det_keyword), m_kw);
            check("det_count", int'(det_count), m_cnt);
        end
    endtask

    task automatic frame(input logic [NK-1:0] res, input int gap);
        cycle(1, res, 0);
        for (int i = 0; i < gap; i++) cycle(0, '0, 0);
    endtask

    task automatic do_reset();
        kws_valid  = 0;
        kws_result = '0;
        det_ready  = 0;
        rst_n      = 0;
        #1;
        check("rst_det_valid", int'(det_valid), 0);
        check("rst_det_keyword", int'(det_keyword), 0);
        check("rst_det_count", int'(det_count), 0);
        check("rst_frame_drop", int'(frame_drop), 0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Basic detection on keyword 3
        cfg_thresh = 5;
        for (int i = 0; i < 5; i++) frame(10'h008, 4);
        check("basic_detected", int'(det_valid), 1);
        check("basic_kw", int'(det_keyword), 3);
        check("basic_cnt", int'(det_count), 5);

        // Back-pressure: three frames dropped while det_ready is low
        drops = 0;
        for (int i = 0; i < 10; i++) cycle((i % 3) == 1, 10'h3FF, 0);
        check("bp_drops", drops, 3);
        cycle(0, '0, 1);
        check("bp_accepted", int'(det_valid), 0);
        drops = 0;
        for (int i = 0; i < HOLD; i++) frame(10'h008, 2);
        check("holdoff_drops", drops, HOLD);
        cfg_thresh = 1;
        frame(10'h008, 3);
        check("post_hold_cnt", int'(det_count), 1);
        cycle(0, '0, 1);
        for (int i = 0; i < HOLD; i++) frame('0, 1);

        // Slide-out: peak count 4 never reaches 5
        do_reset();
        cfg_thresh = 5;
        drops = 0;
        for (int i = 0; i < 16; i++) frame((i % 2 == 0) ? 10'h008 : 10'h000, 2);
        check("slide_no_det", int'(det_valid), 0);
        check("slide_no_drop", drops, 0);

        // Tie-break between keywords 5 and 7
        do_reset();
        cfg_thresh = 3;
        for (int i = 0; i < 3; i++) frame(10'h0A0, 2);
        check("tie_kw", int'(det_keyword), 5);
        check("tie_cnt", int'(det_count), 3);

        // Disabled and over-range thresholds
        do_reset();
        cfg_thresh = 0;
        for (int i = 0; i < 8; i++) frame(10'h3FF, 1);
        check("thresh0_no_det", int'(det_valid), 0);
        cfg_thresh = 9;
        for (int i = 0; i < 8; i++) frame(10'h3FF, 1);
        check("thresh9_no_det", int'(det_valid), 0);

        // Reset while a detection is pending
        do_reset();
        cfg_thresh = 5;
        for (int i = 0; i < 5; i++) frame(10'h008, 1);
        check("pre_rst_valid", int'(det_valid), 1);
        rst_n = 0;
        #1;
        check("mid_rst_valid", int'(det_valid), 0);
        @(negedge clk);
        model_reset();
        rst_n = 1;
        for (int i = 0; i < 4; i++) frame(10'h008, 2);
        check("post_rst_no_det", int'(det_valid), 0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            logic [NK-1:0] res;
            if (c % 64 == 0) cfg_thresh = CNT_W'($urandom_range(0, 9));
            res = NK'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) res = res | NK'($urandom);
            if ($urandom_range(0, 7) == 0) res = '0;
            cycle($urandom_range(0, 2) == 0, res, $urandom_range(0, 4) < 2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
